// File: rtl/num_text_pkg.sv
// Shared mode/state encodings and ASCII helpers for the numeric text row.
package num_text_pkg;

  typedef enum logic [1:0] {
    MODE_BIN    = 2'd0,
    MODE_HEX    = 2'd1,
    MODE_DEC    = 2'd2,
    MODE_HEXDEC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'd0, n} : ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/num_text_row_bin_to_bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin_to_bcd #(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned DEC_DIGITS  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [VALUE_WIDTH-1:0]    value,
  output logic                      done,
  output logic [4*DEC_DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DEC_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]       remaining;

  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return {r[BCD_W-2:0], bit_in};
  endfunction

  // The MSB is consumed on the start edge itself, so done pulses in the
  // VALUE_WIDTH-th cycle after start with the digits already settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bcd       <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (start) begin
      bcd       <= dd_step('0, value[VALUE_WIDTH-1]);
      shreg     <= value << 1;
      remaining <= CNT_W'(VALUE_WIDTH - 1);
      done      <= (VALUE_WIDTH == 1);
    end else if (remaining != '0) begin
      bcd       <= dd_step(bcd, shreg[VALUE_WIDTH-1]);
      shreg     <= shreg << 1;
      remaining <= remaining - 1'b1;
      done      <= (remaining == CNT_W'(1));
    end else begin
      done      <= 1'b0;
    end
  end

endmodule

// File: rtl/num_text_row.sv
// One ASCII text row rendering a value as BIN, HEX, DEC or HEX+DEC from an
// atomically committed snapshot; decimal digits come from a sequential converter.
module num_text_row
  import num_text_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned ROW_CHARS   = 16,
  parameter int unsigned DEC_DIGITS  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VALUE_WIDTH-1:0]       valueIn,
  input  logic                         valueValid,
  input  logic [1:0]                   mode,
  output logic                         busy,
  input  logic [$clog2(ROW_CHARS)-1:0] charAddress,
  output logic [7:0]                   charOutput
);

  localparam int unsigned HEX_DIGITS = (VALUE_WIDTH + 3) / 4;
  localparam int unsigned BCD_W      = 4 * DEC_DIGITS;
  localparam int unsigned BIN_COLS   = (VALUE_WIDTH < ROW_CHARS) ? VALUE_WIDTH : ROW_CHARS;

  if (VALUE_WIDTH < 1 || VALUE_WIDTH > 32 || ROW_CHARS < 2 ||
      (ROW_CHARS & (ROW_CHARS - 1)) != 0 ||
      VALUE_WIDTH * 301030 > DEC_DIGITS * 1000000 ||
      HEX_DIGITS + 2 > ROW_CHARS || DEC_DIGITS > ROW_CHARS ||
      HEX_DIGITS + DEC_DIGITS + 1 > ROW_CHARS) begin : g_param_check
    $error("num_text_row: illegal parameter combination");
  end

  state_e                 state, state_next;
  logic                   start, take_pend, commit, done;
  logic [VALUE_WIDTH-1:0] conv_value, lat_value, pend_value, snap_value;
  mode_e                  conv_mode, lat_mode, pend_mode, snap_mode;
  logic                   pend_full;
  logic [BCD_W-1:0]       bcd, snap_bcd;
  logic [31:0]            val32;
  int unsigned            col, pos, msd;
  logic [7:0]             glyph;

  bin_to_bcd #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bcd (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .value(conv_value),
    .done (done),
    .bcd  (bcd)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take_pend  = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valueValid || pend_full) begin
          start      = 1'b1;
          take_pend  = !valueValid;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (done) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit = 1'b1;
        if (pend_full) begin
          start      = 1'b1;
          take_pend  = 1'b1;
          state_next = ST_CONVERT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign conv_value = take_pend ? pend_value : valueIn;
  assign conv_mode  = take_pend ? pend_mode  : mode_e'(mode);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A load seen in COMMIT lands in the slot even while the slot is being
  // consumed, so the newest value always survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full  <= 1'b0;
      pend_value <= '0;
      pend_mode  <= MODE_BIN;
    end else if (valueValid && state != ST_IDLE) begin
      pend_full  <= 1'b1;
      pend_value <= valueIn;
      pend_mode  <= mode_e'(mode);
    end else if (start) begin
      pend_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_value  <= '0;
      lat_mode   <= MODE_BIN;
      snap_value <= '0;
      snap_mode  <= MODE_BIN;
      snap_bcd   <= '0;
    end else begin
      if (start) begin
        lat_value <= conv_value;
        lat_mode  <= conv_mode;
      end
      if (commit) begin
        snap_value <= lat_value;
        snap_mode  <= lat_mode;
        snap_bcd   <= bcd;
      end
    end
  end

  assign val32 = 32'(snap_value);

  always_comb begin
    msd = 0;
    for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
      if (snap_bcd[4*i +: 4] != 4'd0) msd = i;
    end
  end

  // pos counts columns from the right edge; digits above msd render as spaces.
  always_comb begin
    col   = 32'(charAddress);
    pos   = ROW_CHARS - 1 - col;
    glyph = ASCII_SPACE;
    case (snap_mode)
      MODE_BIN: begin
        if (pos < BIN_COLS) glyph = (((val32 >> pos) & 32'd1) != 32'd0) ? ASCII_ONE : ASCII_ZERO;
      end
      MODE_HEX: begin
        if (pos < HEX_DIGITS)          glyph = nibble_to_ascii(4'(val32 >> (4 * pos)));
        else if (pos == HEX_DIGITS)     glyph = ASCII_X;
        else if (pos == HEX_DIGITS + 1) glyph = ASCII_ZERO;
      end
      MODE_DEC: begin
        if (pos <= msd) glyph = nibble_to_ascii(4'(snap_bcd >> (4 * pos)));
      end
      MODE_HEXDEC: begin
        if (col < HEX_DIGITS) glyph = nibble_to_ascii(4'(val32 >> (4 * (HEX_DIGITS - 1 - col))));
        else if (pos <= msd)  glyph = nibble_to_ascii(4'(snap_bcd >> (4 * pos)));
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) charOutput <= ASCII_SPACE;
    else       charOutput <= glyph;
  end

endmodule

// File: tb/tb_num_text_row.sv
// Randomized and directed bench for num_text_row against a job-timeline text model.
module tb_num_text_row;

  localparam int W   = 16;
  localparam int ROW = 16;
  localparam int HD  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valueIn;
  logic        valueValid;
  logic [1:0]  mode;
  logic        busy;
  logic [3:0]  charAddress;
  logic [7:0]  charOutput;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  num_text_row #(
    .VALUE_WIDTH(W),
    .ROW_CHARS  (ROW),
    .DEC_DIGITS (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valueIn    (valueIn),
    .valueValid (valueValid),
    .mode       (mode),
    .busy       (busy),
    .charAddress(charAddress),
    .charOutput (charOutput)
  );

  always #5 clk = ~clk;

  // Text the row must show for a value/mode, built directly from the layout rules.
  function automatic logic [7:0] model_char(int unsigned v, int md, int col);
    logic [7:0] row [ROW];
    string hexd = "0123456789ABCDEF";
    string d;
    int nd;
    for (int i = 0; i < ROW; i++) row[i] = 8'h20;
    d  = $sformatf("%0d", v);
    nd = d.len();
    case (md)
      0: for (int b = 0; b < W && b < ROW; b++) row[ROW-1-b] = (((v >> b) & 1) != 0) ? "1" : "0";
      1: begin
        for (int i = 0; i < HD; i++) row[ROW-1-i] = hexd.getc(int'((v >> (4*i)) & 15));
        row[ROW-1-HD] = "x";
        row[ROW-2-HD] = "0";
      end
      2: for (int i = 0; i < nd; i++) row[ROW-nd+i] = d.getc(i);
      default: begin
        for (int i = 0; i < HD; i++) row[HD-1-i] = hexd.getc(int'((v >> (4*i)) & 15));
        for (int i = 0; i < nd; i++) row[ROW-nd+i] = d.getc(i);
      end
    endcase
    return row[col];
  endfunction

  // Model: a job occupies W+1 busy cycles, its last being the commit; one pending slot.
  int unsigned m_left = 0, m_job_val = 0, m_slot_val = 0, m_snap_val = 0;
  int          m_job_mode = 0, m_slot_mode = 0, m_snap_mode = 0;
  bit          m_slot_full = 0, m_busy = 0;
  logic [7:0]  m_char = 8'h20;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_slot_full = 0; m_snap_val = 0; m_snap_mode = 0;
      m_char = 8'h20; m_busy = 0;
    end else begin
      m_char = model_char(m_snap_val, m_snap_mode, int'(charAddress));
      if (m_left == 0) begin
        if (valueValid) begin
          m_job_val = valueIn; m_job_mode = int'(mode); m_slot_full = 0; m_left = W + 1;
        end else if (m_slot_full) begin
          m_job_val = m_slot_val; m_job_mode = m_slot_mode; m_slot_full = 0; m_left = W + 1;
        end
      end else if (m_left == 1) begin
        m_snap_val = m_job_val; m_snap_mode = m_job_mode;
        if (m_slot_full) begin
          m_job_val = m_slot_val; m_job_mode = m_slot_mode; m_left = W + 1;
        end else begin
          m_left = 0;
        end
        m_slot_full = valueValid;
        if (valueValid) begin m_slot_val = valueIn; m_slot_mode = int'(mode); end
      end else begin
        m_left--;
        if (valueValid) begin m_slot_full = 1; m_slot_val = valueIn; m_slot_mode = int'(mode); end
      end
      m_busy = (m_left != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy_cycle t=%0t got %0b want %0b", $time, busy, m_busy);
      end
      checks++;
      if (charOutput !== m_char) begin
        errors++;
        $display("FAIL char_cycle t=%0t addr %0d got %h want %h", $time, charAddress, charOutput, m_char);
      end
    end
  end

  task automatic check_num(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [8*ROW-1:0] act, input logic [8*ROW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got \"%s\" want \"%s\"", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [1:0] m);
    valueIn = v; mode = m; valueValid = 1'b1;
    @(negedge clk);
    valueValid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic wait_idle();
    int n;
    count_busy(n);
    check_num("idle_timeout", longint'(busy), 0);
  endtask

  task automatic read_row(output logic [8*ROW-1:0] r);
    r = '0;
    for (int c = 0; c < ROW; c++) begin
      charAddress = 4'(c);
      @(posedge clk); #1;
      r = {r[8*ROW-9:0], charOutput};
      @(negedge clk);
    end
  endtask

  initial begin : main
    logic [8*ROW-1:0] row;
    int n, falls;
    bit seen0, seen7, prev_busy;
    valueValid = 1'b0; valueIn = '0; mode = 2'd0; charAddress = '0;

    @(posedge clk); chk_en = 1;
    @(negedge clk);
    check_num("reset_char", longint'(charOutput), 32);
    check_num("reset_busy", longint'(busy), 0);
    @(negedge clk); reset = 1'b0;
    read_row(row);
    check_row("bin_zero", row, "0000000000000000");
    check_num("idle_busy", longint'(busy), 0);

    load(16'd12345, 2'd2);
    count_busy(n);
    check_num("busy_len_12345", n, 17);
    read_row(row);
    check_row("dec_12345", row, "           12345");

    load(16'hBEEF, 2'd1);
    wait_idle();
    read_row(row);
    check_row("hex_beef", row, "          0xBEEF");

    load(16'd0, 2'd2);
    wait_idle();
    read_row(row);
    check_row("dec_zero", row, "               0");

    load(16'd65535, 2'd3);
    wait_idle();
    read_row(row);
    check_row("hexdec_ffff", row, "FFFF       65535");

    charAddress = 4'd15;
    load(16'd100, 2'd2);
    n = 0; falls = 0; seen0 = 0; seen7 = 0; prev_busy = 1;
    for (int k = 0; k < 60; k++) begin
      if (busy) n++;
      if (prev_busy && !busy) falls++;
      prev_busy = busy;
      valueValid = (k == 3 || k == 6);
      valueIn = (k == 3) ? 16'd7 : 16'd42;
      mode = 2'd2;
      @(posedge clk); #1;
      if (charOutput == 8'h30) seen0 = 1;
      if (charOutput == 8'h37) seen7 = 1;
      @(negedge clk);
    end
    valueValid = 1'b0;
    check_num("chain_busy_len", n, 34);
    check_num("chain_busy_falls", falls, 1);
    check_num("chain_saw_100", longint'(seen0), 1);
    check_num("chain_saw_7", longint'(seen7), 0);
    read_row(row);
    check_row("dec_42", row, "              42");

    load(16'd999, 2'd2);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_num("async_busy", longint'(busy), 0);
    check_num("async_char", longint'(charOutput), 32);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    read_row(row);
    check_row("after_abort", row, "0000000000000000");

    for (int i = 0; i < 500; i++) begin
      valueValid  = ($urandom_range(0, 5) == 0);
      valueIn     = 16'($urandom);
      mode        = 2'($urandom_range(0, 3));
      charAddress = 4'($urandom);
      @(negedge clk);
    end
    valueValid = 1'b0;
    wait_idle();
    repeat (20) begin
      charAddress = 4'($urandom);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
